// File: rtl/vec_algebra_pkg.sv
// Shared types and defaults for the vector algebra blocks (dot product, scale, ...).
package vec_algebra_pkg;

    localparam int unsigned DefSizeArray = 256;
    localparam int unsigned DefSizeInt   = 32;

    typedef logic [DefSizeInt-1:0] elem_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/scale_lane.sv
// Single multiplier lane: unsigned product truncated to the element width.
module scale_lane #(
    parameter int unsigned SIZE_INT = 32
) (
    input  logic [SIZE_INT-1:0] a,
    input  logic [SIZE_INT-1:0] b,
    output logic [SIZE_INT-1:0] p
);

    // Self-determined width keeps only the low SIZE_INT bits (modulo 2^SIZE_INT).
    always_comb begin
        p = a * b;
    end

endmodule

// File: rtl/scalar_scale_vector.sv
// Sequential Y[i] = A * X[i], one element per clock through a shared lane.
module scalar_scale_vector
    import vec_algebra_pkg::*;
#(
    parameter int unsigned SIZE_ARRAY = DefSizeArray,
    parameter int unsigned SIZE_INT   = DefSizeInt
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [SIZE_INT-1:0]            scalar,
    input  logic [SIZE_ARRAY*SIZE_INT-1:0] IX,
    output logic                           busy,
    output logic                           done,
    output logic [SIZE_ARRAY*SIZE_INT-1:0] result
);

    localparam int unsigned SIZE  = SIZE_ARRAY * SIZE_INT;
    localparam int unsigned IDX_W = (SIZE_ARRAY > 1) ? $clog2(SIZE_ARRAY) : 1;
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(SIZE_ARRAY - 1);

    state_e              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [SIZE_INT-1:0] a_q;
    logic [SIZE-1:0]     x_q;
    logic [SIZE_INT-1:0] x_elem;
    logic [SIZE_INT-1:0] prod;

    always_comb begin
        x_elem = x_q[idx_q*SIZE_INT +: SIZE_INT];
    end

    scale_lane #(
        .SIZE_INT (SIZE_INT)
    ) u_lane (
        .a (a_q),
        .b (x_elem),
        .p (prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            a_q     <= '0;
            x_q     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q     <= scalar;
                        x_q     <= IX;
                        result  <= '0;
                        idx_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    result[idx_q*SIZE_INT +: SIZE_INT] <= prod;
                    if (idx_q == LastIdx) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_scalar_scale_vector.sv
// Randomized scoreboard bench for scalar_scale_vector: a small (4-element) and a default instance.
module tb_scalar_scale_vector;

    localparam int NS = 4;
    localparam int NB = 256;
    localparam int W  = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Small instance
    logic            rst_s, start_s, busy_s, done_s;
    logic [W-1:0]    scalar_s;
    logic [NS*W-1:0] ix_s, res_s;

    // Default-size instance
    logic            rst_b, start_b, busy_b, done_b;
    logic [W-1:0]    scalar_b;
    logic [NB*W-1:0] ix_b, res_b;

    scalar_scale_vector #(
        .SIZE_ARRAY (NS),
        .SIZE_INT   (W)
    ) dut_s (
        .clk    (clk),
        .rst    (rst_s),
        .start  (start_s),
        .scalar (scalar_s),
        .IX     (ix_s),
        .busy   (busy_s),
        .done   (done_s),
        .result (res_s)
    );

    scalar_scale_vector dut_b (
        .clk    (clk),
        .rst    (rst_b),
        .start  (start_b),
        .scalar (scalar_b),
        .IX     (ix_b),
        .busy   (busy_b),
        .done   (done_b),
        .result (res_b)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a run accepted at edge T writes element k by edge T+1+k,
    // raises done after edge T+N, and the block accepts again from edge T+N+2.
    typedef struct {
        int              at;
        logic [NS*W-1:0] y;
    } exp_s_t;
    typedef struct {
        int              at;
        logic [NB*W-1:0] y;
    } exp_b_t;

    exp_s_t qs[$];
    exp_b_t qb[$];

    int   edge_n = 0;
    int   s_free = 0, s_t = 0, b_free = 0, b_t = 0;
    bit   s_run = 0, b_run = 0;
    logic [W-1:0] s_y[NS];

    function automatic logic [W-1:0] mul_mod(input logic [W-1:0] a, input logic [W-1:0] x);
        logic [2*W-1:0] full;
        full = {{W{1'b0}}, a} * {{W{1'b0}}, x};
        return full[W-1:0];
    endfunction

    always @(posedge clk) begin
        exp_s_t es;
        exp_b_t eb;
        edge_n++;
        if (rst_s) begin
            s_run = 0;
            qs.delete();
            s_free = edge_n + 1;
        end else if (start_s && edge_n >= s_free) begin
            s_t    = edge_n;
            s_run  = 1;
            s_free = edge_n + NS + 2;
            for (int k = 0; k < NS; k++) begin
                s_y[k] = mul_mod(scalar_s, ix_s[k*W +: W]);
                es.y[k*W +: W] = s_y[k];
            end
            es.at = edge_n + NS;
            qs.push_back(es);
        end
        if (rst_b) begin
            b_run = 0;
            qb.delete();
            b_free = edge_n + 1;
        end else if (start_b && edge_n >= b_free) begin
            b_t    = edge_n;
            b_run  = 1;
            b_free = edge_n + NB + 2;
            for (int k = 0; k < NB; k++) eb.y[k*W +: W] = mul_mod(scalar_b, ix_b[k*W +: W]);
            eb.at = edge_n + NB;
            qb.push_back(eb);
        end
    end

    // Monitor: compares outputs every cycle, pops the scoreboard on each done pulse.
    always @(negedge clk) begin
        logic [NS*W-1:0] exp_res;
        exp_s_t es;
        exp_b_t eb;
        if (edge_n > 0) begin
            for (int k = 0; k < NS; k++)
                exp_res[k*W +: W] = (s_run && edge_n >= s_t + 1 + k) ? s_y[k] : '0;
            chk("s_busy", 128'(busy_s), 128'(s_run && edge_n < s_t + NS));
            chk("s_result", 128'(res_s), 128'(exp_res));
            if (done_s) begin
                if (qs.size() == 0) begin
                    chk("s_done_unexpected", 128'(done_s), 128'(0));
                end else begin
                    es = qs.pop_front();
                    chk("s_done_edge", 128'(edge_n), 128'(es.at));
                    chk("s_done_result", 128'(res_s), 128'(es.y));
                end
            end else if (qs.size() > 0 && edge_n >= qs[0].at) begin
                chk("s_done_missing", 128'(done_s), 128'(1));
                void'(qs.pop_front());
            end

            chk("b_busy", 128'(busy_b), 128'(b_run && edge_n < b_t + NB));
            if (done_b) begin
                if (qb.size() == 0) begin
                    chk("b_done_unexpected", 128'(done_b), 128'(0));
                end else begin
                    eb = qb.pop_front();
                    chk("b_done_edge", 128'(edge_n), 128'(eb.at));
                    for (int k = 0; k < NB; k++)
                        chk("b_elem", 128'(res_b[k*W +: W]), 128'(eb.y[k*W +: W]));
                end
            end else if (qb.size() > 0 && edge_n >= qb[0].at) begin
                chk("b_done_missing", 128'(done_b), 128'(1));
                void'(qb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic small_seq();
        logic [NS*W-1:0] v;
        rst_s = 1'b1; start_s = 1'b0; scalar_s = '0; ix_s = '0;
        repeat (2) @(negedge clk);
        chk("reset_result", 128'(res_s), 128'(0));
        rst_s = 1'b0;
        // Basic run, then scramble the inputs right after acceptance.
        scalar_s = 32'd3;
        ix_s = {32'd4, 32'd3, 32'd2, 32'd1};
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0; scalar_s = $urandom; ix_s = {$urandom, $urandom, $urandom, $urandom};
        repeat (NS + 2) @(negedge clk);
        v = {32'd12, 32'd9, 32'd6, 32'd3};
        chk("basic_result", 128'(res_s), 128'(v));
        // Overflow, with a start pulse in the middle of the run.
        scalar_s = 32'h0001_0000;
        ix_s = {$urandom, $urandom, $urandom, 32'h0003_0002};
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0; scalar_s = 32'd7; ix_s = '1;
        @(negedge clk);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        repeat (NS + 2) @(negedge clk);
        chk("overflow_elem0", 128'(res_s[W-1:0]), 128'(32'h0002_0000));
        // Reset sampled two edges after acceptance.
        scalar_s = 32'd5; ix_s = {32'd1, 32'd2, 32'd3, 32'd4};
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        @(negedge clk);
        rst_s = 1'b1;
        @(negedge clk);
        rst_s = 1'b0;
        chk("midrun_reset_busy", 128'(busy_s), 128'(0));
        repeat (NS + 3) @(negedge clk);
        // Random traffic including occasional resets.
        for (int c = 0; c < 300; c++) begin
            start_s  = ($urandom_range(0, 3) == 0);
            rst_s    = ($urandom_range(0, 59) == 0);
            scalar_s = ($urandom_range(0, 3) == 0) ? '1 : $urandom;
            for (int k = 0; k < NS; k++) ix_s[k*W +: W] = $urandom;
            @(negedge clk);
        end
        rst_s = 1'b0;
        // Level-held start relaunches back to back.
        start_s = 1'b1; scalar_s = 32'd9; ix_s = {32'd10, 32'd20, 32'd30, 32'd40};
        repeat (2 * (NS + 2) + 1) @(negedge clk);
        start_s = 1'b0;
        repeat (NS + 4) @(negedge clk);
    endtask

    task automatic big_seq();
        int t0;
        int seen;
        rst_b = 1'b1; start_b = 1'b0; scalar_b = '0; ix_b = '0;
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        scalar_b = 32'd2;
        for (int k = 0; k < NB; k++) ix_b[k*W +: W] = k;
        start_b = 1'b1;
        @(negedge clk);
        t0 = edge_n;
        // Hold start through the relaunch edge t0+NB+2.
        repeat (NB + 2) @(negedge clk);
        start_b = 1'b0;
        chk("b_relaunch_busy", 128'(busy_b), 128'(1));
        seen = 0;
        for (int c = 0; c < NB + 10 && seen == 0; c++) begin
            @(negedge clk);
            if (done_b) seen = edge_n;
        end
        chk("b_second_done_edge", 128'(seen), 128'(t0 + 2 * NB + 2));
        chk("b_y255", 128'(res_b[255*W +: W]), 128'(32'd510));
        repeat (4) @(negedge clk);
    endtask

    initial begin
        fork
            small_seq();
            big_seq();
        join
        repeat (3) @(negedge clk);
        chk("s_scoreboard_drained", 128'(qs.size()), 128'(0));
        chk("b_scoreboard_drained", 128'(qb.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
